// File: rtl/ram_ctrl.sv
// Latency-configurable single-port word RAM controller with byte-strobed writes.
// Requests are qualified in FREE, held through LAT BUSY cycles, and serviced in one ACCESS cycle.
module ram_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_store,
    input  logic [3:0]  ram_strobe,
    input  logic        ram_ren,
    input  logic        ram_wen,
    output logic [31:0] ram_load,
    output logic [1:0]  ram_state
);

    localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT    = 4'(LAT);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t        state_reg,  state_next;
    logic [3:0]    cnt_reg,    cnt_next;
    logic [AW-1:0] addr_reg,   addr_next;
    logic [31:0]   store_reg,  store_next;
    logic [3:0]    strobe_reg, strobe_next;
    logic          write_reg,  write_next;
    logic [31:0]   rd_word;
    logic          req_ok;
    logic          req_live;

    // Exactly one request line, word aligned, and inside the backing store.
    assign req_ok   = (ram_ren ^ ram_wen) && (ram_addr[1:0] == 2'b00) &&
                      (ram_addr[31:2] < DEPTH_LIMIT);
    assign req_live = write_reg ? ram_wen : ram_ren;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        store_next  = store_reg;
        strobe_next = strobe_reg;
        write_next  = write_reg;
        case (state_reg)
            FREE: begin
                if (req_ok) begin
                    addr_next   = ram_addr[AW+1:2];
                    store_next  = ram_store;
                    strobe_next = ram_strobe;
                    write_next  = ram_wen;
                    cnt_next    = LAT_INIT;
                    state_next  = (LAT_INIT == 4'd0) ? ACCESS : BUSY;
                end else if (ram_ren || ram_wen) begin
                    state_next = ERROR;
                end
            end
            BUSY: begin
                // Requester withdrawing its line cancels the pending operation.
                if (!req_live) begin
                    state_next = FREE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS:  state_next = FREE;
            ERROR:   state_next = FREE;
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= FREE;
            cnt_reg    <= 4'd0;
            addr_reg   <= '0;
            store_reg  <= 32'd0;
            strobe_reg <= 4'd0;
            write_reg  <= 1'b0;
            ram_load   <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            store_reg  <= store_next;
            strobe_reg <= strobe_next;
            write_reg  <= write_next;
            // Read data is captured on the edge that enters a read ACCESS, then held.
            if (state_next == ACCESS && !write_next) begin
                ram_load <= rd_word;
            end
        end
    end

    // Storage is split into byte lanes so each strobe bit gates its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge CLK) begin
                if (state_reg == ACCESS && write_reg && strobe_reg[gi]) begin
                    lane_mem[addr_reg] <= store_reg[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[addr_next];
        end
    endgenerate

    assign ram_state = state_reg;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: three instances (LAT=2, LAT=3, LAT=0) share clock, reset and data bus.
module tb_ram_ctrl;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        nrst;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [3:0]  ram_strobe;
    logic [2:0]  ren;
    logic [2:0]  wen;
    logic [1:0]  st [3];
    logic [31:0] ld [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    ram_ctrl #(.DEPTH_WORDS(DEPTH), .LAT(2)) u_dut_lat2 (
        .CLK(clk), .nRST(nrst), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_strobe(ram_strobe), .ram_ren(ren[0]), .ram_wen(wen[0]),
        .ram_load(ld[0]), .ram_state(st[0])
    );

    ram_ctrl #(.DEPTH_WORDS(DEPTH), .LAT(3)) u_dut_lat3 (
        .CLK(clk), .nRST(nrst), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_strobe(ram_strobe), .ram_ren(ren[1]), .ram_wen(wen[1]),
        .ram_load(ld[1]), .ram_state(st[1])
    );

    ram_ctrl #(.DEPTH_WORDS(DEPTH), .LAT(0)) u_dut_lat0 (
        .CLK(clk), .nRST(nrst), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_strobe(ram_strobe), .ram_ren(ren[2]), .ram_wen(wen[2]),
        .ram_load(ld[2]), .ram_state(st[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on instance u and records the state after each edge (oldest in the high bits).
    task automatic xact(input int u, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int n_edges,
                        input int drop_at, input bit mutate, input bit keep,
                        output logic [15:0] seq, output logic [31:0] acc_load);
        ram_addr   = a;
        ram_store  = d;
        ram_strobe = s;
        ren[u]     = rd;
        wen[u]     = wr;
        seq        = {14'd0, st[u]};
        acc_load   = 'x;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk);
            #1;
            seq = {seq[13:0], st[u]};
            if (st[u] == 2'd2) acc_load = ld[u];
            if (mutate && e == 1) begin
                ram_addr   = a ^ 32'h4;
                ram_store  = ~d;
                ram_strobe = 4'h0;
            end
            if ((!keep && (st[u] == 2'd2 || st[u] == 2'd3)) || e == drop_at) begin
                ren[u] = 1'b0;
                wen[u] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        ram_addr = 32'd0; ram_store = 32'd0; ram_strobe = 4'd0;
        ren = 3'b000; wen = 3'b000;
        #3;
        total_cnt++;
        if (st[0] !== 2'd0) $display("FAIL reset_state: got %0d want 0", st[0]); else pass_cnt++;
        total_cnt++;
        if (ld[0] !== 32'd0) $display("FAIL reset_load: got %h want 00000000", ld[0]); else pass_cnt++;
        ren[2] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if (st[2] !== 2'd0) $display("FAIL reset_hold: got %0d want 0", st[2]); else pass_cnt++;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (st[2] !== 2'd2) $display("FAIL first_edge_req: got %0d want 2", st[2]); else pass_cnt++;
        ren[2] = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (st[2] !== 2'd0) $display("FAIL first_edge_free: got %0d want 0", st[2]); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        exp = 16'({2'd0, 2'd1, 2'd1, 2'd2, 2'd0});
        xact(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL wr_seq: got %h want %h", seq, exp); else pass_cnt++;
        xact(0, 0, 1, 32'h10, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL rd_seq: got %h want %h", seq, exp); else pass_cnt++;
        total_cnt++;
        if (acc !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", acc); else pass_cnt++;
        total_cnt++;
        if (ld[0] !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", ld[0]); else pass_cnt++;
        $display("test_write_read done");
    endtask

    task automatic test_strobe();
        logic [15:0] seq;
        logic [31:0] acc;
        xact(0, 1, 0, 32'h10, 32'h11223344, 4'b0101, 4, -1, 0, 0, seq, acc);
        xact(0, 0, 1, 32'h10, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'hDE22BE44) $display("FAIL strobe_0101: got %h want de22be44", acc); else pass_cnt++;
        xact(0, 1, 0, 32'h10, 32'hFFFFFFFF, 4'b0000, 4, -1, 0, 0, seq, acc);
        xact(0, 0, 1, 32'h10, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'hDE22BE44) $display("FAIL strobe_zero: got %h want de22be44", acc); else pass_cnt++;
        $display("test_strobe done");
    endtask

    task automatic test_errors();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        exp = 16'({2'd0, 2'd3, 2'd0, 2'd0});
        xact(0, 0, 1, 32'h13, 32'h0, 4'h0, 3, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL err_misaligned: got %h want %h", seq, exp); else pass_cnt++;
        xact(0, 0, 1, 32'(4 * DEPTH), 32'h0, 4'h0, 3, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL err_range: got %h want %h", seq, exp); else pass_cnt++;
        xact(0, 1, 1, 32'h10, 32'h0, 4'hF, 3, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL err_both: got %h want %h", seq, exp); else pass_cnt++;
        total_cnt++;
        if (ld[0] !== 32'hDE22BE44) $display("FAIL err_load_kept: got %h want de22be44", ld[0]); else pass_cnt++;
        xact(0, 1, 0, 32'h12, 32'h0, 4'hF, 3, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL err_wr_misaligned: got %h want %h", seq, exp); else pass_cnt++;
        xact(0, 0, 1, 32'h10, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'hDE22BE44) $display("FAIL err_storage: got %h want de22be44", acc); else pass_cnt++;
        xact(0, 1, 0, 32'(4 * DEPTH - 4), 32'h600DCAFE, 4'hF, 4, -1, 0, 0, seq, acc);
        xact(0, 0, 1, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'h600DCAFE) $display("FAIL last_word: got %h want 600dcafe", acc); else pass_cnt++;
        $display("test_errors done");
    endtask

    task automatic test_busy_ignore();
        logic [15:0] seq;
        logic [31:0] acc;
        xact(0, 1, 0, 32'h30, 32'hA5A5A5A5, 4'hF, 4, -1, 1, 0, seq, acc);
        xact(0, 0, 1, 32'h30, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'hA5A5A5A5) $display("FAIL busy_ignore: got %h want a5a5a5a5", acc); else pass_cnt++;
        $display("test_busy_ignore done");
    endtask

    task automatic test_hold_request();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        exp = 16'({2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1});
        xact(0, 0, 1, 32'h10, 32'h0, 4'h0, 5, 5, 0, 1, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL hold_rerequest: got %h want %h", seq, exp); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (st[0] !== 2'd0) $display("FAIL rd_abort: got %0d want 0", st[0]); else pass_cnt++;
        $display("test_hold_request done");
    endtask

    task automatic test_abort();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        exp = 16'({2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0});
        xact(1, 1, 0, 32'h20, 32'h12345678, 4'hF, 5, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL lat3_seq: got %h want %h", seq, exp); else pass_cnt++;
        exp = 16'({2'd0, 2'd1, 2'd1, 2'd0, 2'd0});
        xact(1, 1, 0, 32'h20, 32'hCAFEF00D, 4'hF, 4, 2, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL abort_seq: got %h want %h", seq, exp); else pass_cnt++;
        xact(1, 0, 1, 32'h20, 32'h0, 4'h0, 5, -1, 0, 0, seq, acc);
        total_cnt++;
        if (acc !== 32'h12345678) $display("FAIL abort_data: got %h want 12345678", acc); else pass_cnt++;
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        exp = 16'({2'd0, 2'd2, 2'd0});
        xact(2, 1, 0, 32'h40, 32'h55AA00FF, 4'hF, 2, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL lat0_wr_seq: got %h want %h", seq, exp); else pass_cnt++;
        xact(2, 0, 1, 32'h40, 32'h0, 4'h0, 2, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL lat0_rd_seq: got %h want %h", seq, exp); else pass_cnt++;
        total_cnt++;
        if (acc !== 32'h55AA00FF) $display("FAIL b2b_data: got %h want 55aa00ff", acc); else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] seq, exp;
        logic [31:0] acc;
        xact(0, 1, 0, 32'h50, 32'h0BADF00D, 4'hF, 4, -1, 0, 0, seq, acc);
        xact(0, 0, 1, 32'h50, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        ram_addr = 32'h50; ram_store = 32'hFFFFFFFF; ram_strobe = 4'hF;
        wen[0] = 1'b1;
        @(posedge clk); #3;
        total_cnt++;
        if (st[0] !== 2'd1) $display("FAIL rst_pre_busy: got %0d want 1", st[0]); else pass_cnt++;
        nrst = 1'b0;
        #1;
        total_cnt++;
        if (st[0] !== 2'd0) $display("FAIL rst_async_state: got %0d want 0", st[0]); else pass_cnt++;
        total_cnt++;
        if (ld[0] !== 32'd0) $display("FAIL rst_async_load: got %h want 00000000", ld[0]); else pass_cnt++;
        wen[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        exp = 16'({2'd0, 2'd1, 2'd1, 2'd2, 2'd0});
        xact(0, 0, 1, 32'h50, 32'h0, 4'h0, 4, -1, 0, 0, seq, acc);
        total_cnt++;
        if (seq !== exp) $display("FAIL rst_after_seq: got %h want %h", seq, exp); else pass_cnt++;
        total_cnt++;
        if (acc !== 32'h0BADF00D) $display("FAIL rst_no_write: got %h want 0badf00d", acc); else pass_cnt++;
        $display("test_reset_mid_busy done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_busy_ignore();
        test_hold_request();
        test_abort();
        test_back_to_back();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
